// File: rtl/multicycle_control_unit_if.sv
// Control-unit bundle: instruction opcode and memory handshake in,
// datapath enables, mux selects, status and retire count out.
interface multicycle_control_unit_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             mem_ready;
  logic [2:0]       state;
  logic             pcWrite;
  logic             irWrite;
  logic             iorD;
  logic [1:0]       ALUOp;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic             branch;
  logic [1:0]       jumpType;
  logic             memRead;
  logic             memWrite;
  logic             memToReg;
  logic             regWrite;
  logic             halted;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] instret;

  // The control unit drives the datapath controls.
  modport master (
    input  opcode, mem_ready,
    output state, pcWrite, irWrite, iorD, ALUOp, ALUSrcA, ALUSrcB, branch,
           jumpType, memRead, memWrite, memToReg, regWrite, halted,
           trap_cause, instret
  );

  // The datapath / memory side supplies the opcode and handshake.
  modport slave (
    output opcode, mem_ready,
    input  state, pcWrite, irWrite, iorD, ALUOp, ALUSrcA, ALUSrcB, branch,
           jumpType, memRead, memWrite, memToReg, regWrite, halted,
           trap_cause, instret
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: BOOT/FETCH/DECODE/EXEC/MEM/WB/TRAP.
// Controls decode from the registered state and latched instruction class;
// retire counter and trap cause are registers.
module multicycle_control_unit #(
  parameter bit ENABLE_U_TYPE = 1'b1,
  parameter int MEM_TIMEOUT   = 16,
  parameter int CNT_W         = 32
) (
  input logic                      clk,
  input logic                      rst_n,
  multicycle_control_unit_if.master bus
);

  typedef enum logic [2:0] {
    BOOT = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
    MEM = 3'd4, WB = 3'd5, TRAP = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILLEGAL
  } class_t;

  // Timeout fires on the last allowed waiting cycle unless mem_ready arrives.
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

  state_t           state_reg, state_next;
  class_t           cls_reg;
  class_t           dec_cls;
  logic [7:0]       wait_reg;
  logic [1:0]       cause_reg, cause_next;
  logic [CNT_W-1:0] instret_reg;
  logic             retire;
  logic             timeout;

  logic       pc_write, ir_write, ior_d, alu_src_a, branch_o;
  logic       mem_read, mem_write, mem_to_reg, reg_write, halted_o;
  logic [1:0] alu_op, alu_src_b, jump_type;

  function automatic class_t decode_class(input logic [6:0] op);
    case (op)
      7'b0110011: decode_class = C_R;
      7'b0010011: decode_class = C_I;
      7'b0000011: decode_class = C_LOAD;
      7'b0100011: decode_class = C_STORE;
      7'b1100011: decode_class = C_BRANCH;
      7'b1101111: decode_class = C_JAL;
      7'b1100111: decode_class = C_JALR;
      7'b0110111: decode_class = ENABLE_U_TYPE ? C_LUI : C_ILLEGAL;
      7'b0010111: decode_class = ENABLE_U_TYPE ? C_AUIPC : C_ILLEGAL;
      default:    decode_class = C_ILLEGAL;
    endcase
  endfunction

  assign dec_cls = decode_class(bus.opcode);
  assign timeout = (wait_reg == WAIT_LIMIT) && !bus.mem_ready;

  // Next-state, trap cause and per-state control decode.
  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    pc_write = 1'b0; ir_write = 1'b0; ior_d = 1'b0; alu_src_a = 1'b0;
    branch_o = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0;
    reg_write = 1'b0; halted_o = 1'b0;
    alu_op = 2'b00; alu_src_b = 2'b00; jump_type = 2'b00;
    case (state_reg)
      BOOT: state_next = FETCH;
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = DECODE;
        end else if (timeout) begin
          state_next = TRAP;
          cause_next = 2'b10;
        end
      end
      DECODE: begin
        alu_src_b = 2'b10;
        if (dec_cls == C_ILLEGAL) begin
          state_next = TRAP;
          cause_next = 2'b01;
        end else begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = WB;
        case (cls_reg)
          C_R:      begin alu_src_a = 1'b1; alu_op = 2'b10; end
          C_I:      begin alu_src_a = 1'b1; alu_src_b = 2'b10; alu_op = 2'b10; end
          C_LOAD, C_STORE: begin
            alu_src_a = 1'b1; alu_src_b = 2'b10; state_next = MEM;
          end
          C_BRANCH: begin
            alu_src_a = 1'b1; alu_op = 2'b01; branch_o = 1'b1; state_next = FETCH;
          end
          C_JAL:    begin jump_type = 2'b10; pc_write = 1'b1; branch_o = 1'b1; alu_op = 2'b11; end
          C_JALR: begin
            jump_type = 2'b01; alu_src_a = 1'b1; alu_src_b = 2'b10;
            pc_write = 1'b1; branch_o = 1'b1; alu_op = 2'b11;
          end
          C_LUI:    begin alu_src_b = 2'b10; alu_op = 2'b11; end
          C_AUIPC:  alu_src_b = 2'b10;
          default:  state_next = TRAP;
        endcase
      end
      MEM: begin
        ior_d = 1'b1;
        if (cls_reg == C_STORE) mem_write = 1'b1;
        else                    mem_read  = 1'b1;
        if (bus.mem_ready) begin
          state_next = (cls_reg == C_STORE) ? FETCH : WB;
        end else if (timeout) begin
          state_next = TRAP;
          cause_next = 2'b10;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_reg == C_LOAD) || (cls_reg == C_JAL) || (cls_reg == C_JALR);
        state_next = FETCH;
      end
      TRAP:    halted_o = 1'b1;
      default: state_next = BOOT;
    endcase
  end

  assign retire = (state_next == FETCH) &&
                  ((state_reg == EXEC) || (state_reg == MEM) || (state_reg == WB));

  // State, class latch, wait counter, trap cause and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= BOOT;
      cls_reg     <= C_ILLEGAL;
      wait_reg    <= 8'd0;
      cause_reg   <= 2'b00;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      cause_reg <= cause_next;
      if (state_reg == DECODE) cls_reg <= dec_cls;
      if (state_next != state_reg) wait_reg <= 8'd0;
      else if (((state_reg == FETCH) || (state_reg == MEM)) && !bus.mem_ready)
        wait_reg <= wait_reg + 8'd1;
      if (retire) instret_reg <= instret_reg + 1'b1;
    end
  end

  assign bus.state      = state_reg;
  assign bus.pcWrite    = pc_write;
  assign bus.irWrite    = ir_write;
  assign bus.iorD       = ior_d;
  assign bus.ALUOp      = alu_op;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.branch     = branch_o;
  assign bus.jumpType   = jump_type;
  assign bus.memRead    = mem_read;
  assign bus.memWrite   = mem_write;
  assign bus.memToReg   = mem_to_reg;
  assign bus.regWrite   = reg_write;
  assign bus.halted     = halted_o;
  assign bus.trap_cause = cause_reg;
  assign bus.instret    = instret_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (U-type disabled, timeout 4).
// Expected per-cycle state/controls are queued and checked one cycle at a time.
module tb_multicycle_control_unit;

  logic clk;
  logic rst_n;

  multicycle_control_unit_if #(.CNT_W(32)) bus ();

  multicycle_control_unit #(
    .ENABLE_U_TYPE(1'b0),
    .MEM_TIMEOUT  (4),
    .CNT_W        (32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] S_BOOT = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_X = 7'b1111111;

  // ctrl bits: pcWrite irWrite iorD ALUOp[2] ALUSrcA ALUSrcB[2] branch
  //            jumpType[2] memRead memWrite memToReg regWrite halted
  logic [15:0] obs_ctrl;
  assign obs_ctrl = {bus.pcWrite, bus.irWrite, bus.iorD, bus.ALUOp, bus.ALUSrcA,
                     bus.ALUSrcB, bus.branch, bus.jumpType, bus.memRead, bus.memWrite,
                     bus.memToReg, bus.regWrite, bus.halted};

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [15:0] ctrl;
    logic [1:0]  cause;
    logic [31:0] ir;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_ir = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    check({e.tag, ".state"}, 32'(bus.state), 32'(e.st));
    check({e.tag, ".ctrl"}, 32'(obs_ctrl), 32'(e.ctrl));
    check({e.tag, ".cause"}, 32'(bus.trap_cause), 32'(e.cause));
    check({e.tag, ".instret"}, bus.instret, e.ir);
  endtask

  task automatic expect_now(string tag, logic [2:0] st, logic [15:0] ctrl,
                            logic [1:0] cause, int ir);
    exp_t e;
    e.tag = tag; e.st = st; e.ctrl = ctrl; e.cause = cause; e.ir = 32'(ir);
    sb.push_back(e);
    pop_check();
  endtask

  // One clock cycle: drive inputs at the falling edge, check before the next rise.
  task automatic cyc(string tag, logic rdy, logic [6:0] op, logic [2:0] st,
                     logic [15:0] ctrl, logic [1:0] cause);
    @(negedge clk);
    bus.mem_ready = rdy;
    bus.opcode    = op;
    #1;
    expect_now(tag, st, ctrl, cause, exp_ir);
  endtask

  // Reset pulse issued between edges; checks the asynchronous response.
  task automatic do_reset(string tag);
    rst_n = 1'b0;
    #1;
    exp_ir = 0;
    expect_now(tag, S_BOOT, 16'h0000, 2'b00, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    bus.opcode = 7'd0;
    #1;
    expect_now("reset", S_BOOT, 16'h0000, 2'b00, 0);
    cyc("boot", 1'b1, OP_X, S_BOOT, 16'h0000, 2'b00);
    rst_n = 1'b1;

    // R-type, mem_ready high
    cyc("r_fetch", 1'b1, OP_X, S_FETCH, 16'hC110, 2'b00);
    cyc("r_dec", 1'b0, OP_R, S_DECODE, 16'h0200, 2'b00);
    cyc("r_exec", 1'b0, OP_X, S_EXEC, 16'h1400, 2'b00);
    cyc("r_wb", 1'b0, OP_X, S_WB, 16'h0002, 2'b00); exp_ir++;

    // Load with mem_ready delayed 3 cycles in MEM
    cyc("ld_fetch", 1'b1, OP_X, S_FETCH, 16'hC110, 2'b00);
    cyc("ld_dec", 1'b0, OP_LD, S_DECODE, 16'h0200, 2'b00);
    cyc("ld_exec", 1'b0, OP_X, S_EXEC, 16'h0600, 2'b00);
    for (int i = 0; i < 3; i++) cyc("ld_mem_wait", 1'b0, OP_X, S_MEM, 16'h2010, 2'b00);
    cyc("ld_mem", 1'b1, OP_X, S_MEM, 16'h2010, 2'b00);
    cyc("ld_wb", 1'b0, OP_X, S_WB, 16'h0006, 2'b00); exp_ir++;

    // Branch: back to FETCH from EXEC
    cyc("br_fetch", 1'b1, OP_X, S_FETCH, 16'hC110, 2'b00);
    cyc("br_dec", 1'b0, OP_BR, S_DECODE, 16'h0200, 2'b00);
    cyc("br_exec", 1'b0, OP_X, S_EXEC, 16'h0C80, 2'b00); exp_ir++;

    // Store: MEM then FETCH, no WB
    cyc("st_fetch", 1'b1, OP_X, S_FETCH, 16'hC110, 2'b00);
    cyc("st_dec", 1'b0, OP_ST, S_DECODE, 16'h0200, 2'b00);
    cyc("st_exec", 1'b0, OP_X, S_EXEC, 16'h0600, 2'b00);
    cyc("st_mem", 1'b1, OP_X, S_MEM, 16'h2008, 2'b00); exp_ir++;

    // I-ALU, jal, jalr
    cyc("i_fetch", 1'b1, OP_X, S_FETCH, 16'hC110, 2'b00);
    cyc("i_dec", 1'b0, OP_I, S_DECODE, 16'h0200, 2'b00);
    cyc("i_exec", 1'b0, OP_X, S_EXEC, 16'h1600, 2'b00);
    cyc("i_wb", 1'b0, OP_X, S_WB, 16'h0002, 2'b00); exp_ir++;
    cyc("jal_fetch", 1'b1, OP_X, S_FETCH, 16'hC110, 2'b00);
    cyc("jal_dec", 1'b0, OP_JAL, S_DECODE, 16'h0200, 2'b00);
    cyc("jal_exec", 1'b0, OP_X, S_EXEC, 16'h98C0, 2'b00);
    cyc("jal_wb", 1'b0, OP_X, S_WB, 16'h0006, 2'b00); exp_ir++;
    cyc("jalr_fetch", 1'b1, OP_X, S_FETCH, 16'hC110, 2'b00);
    cyc("jalr_dec", 1'b0, OP_JALR, S_DECODE, 16'h0200, 2'b00);
    cyc("jalr_exec", 1'b0, OP_X, S_EXEC, 16'h9EA0, 2'b00);
    cyc("jalr_wb", 1'b0, OP_X, S_WB, 16'h0006, 2'b00); exp_ir++;

    // mem_ready arrives on the 4th (limit) FETCH cycle: no trap
    for (int i = 0; i < 3; i++) cyc("late_fetch_wait", 1'b0, OP_X, S_FETCH, 16'h0110, 2'b00);
    cyc("late_fetch", 1'b1, OP_X, S_FETCH, 16'hC110, 2'b00);
    cyc("late_dec", 1'b0, OP_R, S_DECODE, 16'h0200, 2'b00);
    cyc("late_exec", 1'b0, OP_X, S_EXEC, 16'h1400, 2'b00);
    cyc("late_wb", 1'b0, OP_X, S_WB, 16'h0002, 2'b00); exp_ir++;

    // Reset while a store waits in MEM
    cyc("rst_fetch", 1'b1, OP_X, S_FETCH, 16'hC110, 2'b00);
    cyc("rst_dec", 1'b0, OP_ST, S_DECODE, 16'h0200, 2'b00);
    cyc("rst_exec", 1'b0, OP_X, S_EXEC, 16'h0600, 2'b00);
    cyc("rst_mem", 1'b0, OP_X, S_MEM, 16'h2008, 2'b00);
    #1;
    do_reset("rst_mid_mem");
    cyc("rr_fetch", 1'b1, OP_X, S_FETCH, 16'hC110, 2'b00);
    cyc("rr_dec", 1'b0, OP_R, S_DECODE, 16'h0200, 2'b00);
    cyc("rr_exec", 1'b0, OP_X, S_EXEC, 16'h1400, 2'b00);
    cyc("rr_wb", 1'b0, OP_X, S_WB, 16'h0002, 2'b00); exp_ir++;

    // LUI with U-type disabled: illegal-opcode trap, held
    cyc("lui_fetch", 1'b1, OP_X, S_FETCH, 16'hC110, 2'b00);
    cyc("lui_dec", 1'b0, OP_LUI, S_DECODE, 16'h0200, 2'b00);
    for (int i = 0; i < 20; i++) cyc("lui_trap", 1'b1, OP_R, S_TRAP, 16'h0001, 2'b01);
    do_reset("rst_after_illegal");

    // FETCH timeout
    for (int i = 0; i < 4; i++) cyc("to_fetch_wait", 1'b0, OP_X, S_FETCH, 16'h0110, 2'b00);
    for (int i = 0; i < 3; i++) cyc("to_fetch_trap", 1'b1, OP_R, S_TRAP, 16'h0001, 2'b10);
    do_reset("rst_after_fetch_to");

    // MEM timeout on a load
    cyc("mto_fetch", 1'b1, OP_X, S_FETCH, 16'hC110, 2'b00);
    cyc("mto_dec", 1'b0, OP_LD, S_DECODE, 16'h0200, 2'b00);
    cyc("mto_exec", 1'b0, OP_X, S_EXEC, 16'h0600, 2'b00);
    for (int i = 0; i < 4; i++) cyc("mto_mem_wait", 1'b0, OP_X, S_MEM, 16'h2010, 2'b00);
    cyc("mto_trap", 1'b1, OP_X, S_TRAP, 16'h0001, 2'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
